ttd_multi: RTL and testbench
============================

# ttd_multi

Multi-channel, parameterised time-to-digital converter for the capacitor-ramp sensor front end. One shared ramp counter times up to NCH comparator outputs. Each comparator trips when its capacitor voltage crosses Vref. The block sequences the capacitor reset, captures the ramp count at each comparator's rising edge, removes a fixed offset, saturates, optionally averages, and presents per-channel codes with a valid strobe. It replaces the single-channel converter. Comparator inputs are now synchronised into clk instead of being used as clocks.

## Interface
- CNT_W, 11: ramp counter width; maximum ramp count is 2^CNT_W-1.
- OUT_W, 8: per-channel result width.
- NCH, 2: number of comparator channels.
- OFFSET, 509: count subtracted from every capture.
- RST_CYC, 4: clk cycles rst_cap is held high before each ramp (≥1).
- AVG_LOG2, 0: conversions averaged per output word is 2^AVG_LOG2 (0 = no averaging).

- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- cmp_in, in, NCH: asynchronous comparator outputs.
- start, in, 1: single-cycle pulse that starts a conversion when idle.
- continuous, in, 1: when high, a new conversion starts automatically after each DONE.
- rst_cap, out, 1: capacitor reset, shared by all channels.
- busy, out, 1: high in every state except IDLE.
- data_out, out, NCH*OUT_W: channel k occupies bits [k*OUT_W +: OUT_W].
- ovf, out, NCH: per-channel timeout flag for the current output word.
- data_valid, out, 1: one-cycle pulse when data_out and ovf update.

## Operation
- Synchronisation: each cmp_in bit passes through 2 flops, then an edge detector. rise[k] = sync[k] & ~prev[k].
- FSM states: IDLE, CAPRST, RAMP, DONE.
  - IDLE: rst_cap=1. Moves to CAPRST on start, or on continuous=1.
  - CAPRST: rst_cap=1 for exactly RST_CYC cycles. Ramp counter and per-channel captured flags are cleared. Moves to RAMP.
  - RAMP: rst_cap=0. Counter starts at 0 and increments once per cycle.
    - A channel latches the counter value on its first rise while not yet captured. Later edges in the same ramp are ignored.
    - Moves to DONE when all channels have captured, or when the counter equals 2^CNT_W-1.
    - Any uncaptured channel then takes the value 2^CNT_W-1 and sets its timeout bit.
  - DONE: one cycle. Computes each result, updates the accumulator, then goes to CAPRST if continuous=1, otherwise to IDLE.
- Per-channel result = clamp(capture − OFFSET, 0, 2^OUT_W−1).
  - Use signed arithmetic of width CNT_W+1.
  - No wrap-around is permitted. This fixes the modulo behaviour of the previous block.
- Averaging:
  - The accumulator is OUT_W+AVG_LOG2 bits per channel.
  - Timeout bits are ORed across the conversions in a window.
  - After 2^AVG_LOG2 DONE cycles, data_out = acc >> AVG_LOG2 (truncating) and ovf = the ORed bits. The accumulator, timeout bits and conversion counter then clear.
- start is ignored while busy=1. Lowering continuous mid-conversion finishes the current conversion, then the block returns to IDLE.
- A channel already high at RAMP entry has no rising edge. It times out unless it falls and rises again within the ramp.

## Timing
- Reset values:
  - state = IDLE, so rst_cap=1 and busy=0.
  - data_out=0, ovf=0, data_valid=0.
  - Accumulators, counters and sync flops are 0.
- rst at any point, including mid-RAMP, returns the block to IDLE on the next edge. Partial averages are discarded and no data_valid is issued.
- Conversion sequence:
  - start sampled high in IDLE: busy=1 and rst_cap=1 from the next cycle.
  - RAMP begins RST_CYC cycles later. Counter value 0 is present in the first RAMP cycle.
- Capture latency: a cmp_in rising before clk edge n is recorded with the counter value present in cycle n+2, due to the synchroniser. OFFSET absorbs this delay.
- Output timing: data_out, ovf and data_valid update on the clk edge that leaves DONE. data_out and ovf hold until the next valid.
- Back-to-back conversions (continuous=1): the next CAPRST immediately follows DONE. Conversion period = RST_CYC + ramp length + 1 cycles.

## Test plan
Parameters are NCH=2, CNT_W=11, OUT_W=8, OFFSET=509, RST_CYC=4, unless a scenario says otherwise.

1. Reset: assert rst for 3 cycles, then release → data_out=0, ovf=0, data_valid=0, rst_cap=1, busy=0. With no start, IDLE persists.
2. Nominal, AVG_LOG2=0: start; ch0 captures 600, ch1 captures 700 → ch0=91, ch1=191, ovf=00. data_valid is high for exactly 1 cycle, the cycle after the last capture + DONE. rst_cap is high for 4 cycles before the ramp.
3. Saturation: ch0 captures 400, ch1 captures 900 → ch0=0, ch1=255, ovf=00.
4. Timeout: ch0 captures 600, ch1 never rises → RAMP lasts until count 2047. Result ch0=91, ch1=255, ovf=10 (ch1 is bit 1).
5. Averaging, AVG_LOG2=2, continuous=1: ch0 captures 600, 602, 604, 606 → a single data_valid after the 4th DONE with ch0=94. Consecutive ramps are separated by exactly 5 cycles (DONE + 4 CAPRST).
6. Reset mid-RAMP: assert rst at count 300 with 2 of 4 averages accumulated → IDLE next cycle with rst_cap=1, and no data_valid. A subsequent 4-conversion window averages only the new captures.

Source files
------------

// File: rtl/ttd_multi.sv
// Multi-channel time-to-digital converter: one shared ramp counter times NCH
// synchronised comparator edges, then offsets, saturates and optionally averages them.
module ttd_multi #(
  parameter int CNT_W    = 11,
  parameter int OUT_W    = 8,
  parameter int NCH      = 2,
  parameter int OFFSET   = 509,
  parameter int RST_CYC  = 4,
  parameter int AVG_LOG2 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       cmp_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 rst_cap,
  output logic                 busy,
  output logic [NCH*OUT_W-1:0] data_out,
  output logic [NCH-1:0]       ovf,
  output logic                 data_valid
);

  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int RC_W  = $clog2(RST_CYC + 1);
  localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic signed [CNT_W:0] OFF_S   = (CNT_W+1)'(OFFSET);
  localparam logic signed [CNT_W:0] SAT_S   = (CNT_W+1)'((1 << OUT_W) - 1);
  localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(RST_CYC - 1);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, CAPRST, RAMP, DONE} state_t;
  state_t state, state_nxt;

  logic [NCH-1:0]          sync1, sync2, prev, rise;
  logic [NCH-1:0]          captured, timeout, ovf_acc, ovf_sum;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cap_val [NCH];
  logic signed [CNT_W:0]   diff    [NCH];
  logic [OUT_W-1:0]        result  [NCH];
  logic [ACC_W-1:0]        acc     [NCH];
  logic [ACC_W-1:0]        acc_sum [NCH];
  logic [ACC_W-1:0]        avg_val [NCH];
  logic [RC_W-1:0]         rc_cnt;
  logic [WIN_W-1:0]        win_cnt;
  logic                    ramp_end;

  // Two-flop synchroniser plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= cmp_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise     = sync2 & ~prev;
  assign ramp_end = (&(captured | rise)) || (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rst_cap   = 1'b1;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start || continuous) state_nxt = CAPRST;
      end
      CAPRST: if (rc_cnt == RC_LAST) state_nxt = RAMP;
      RAMP: begin
        rst_cap = 1'b0;
        if (ramp_end) state_nxt = DONE;
      end
      DONE: state_nxt = continuous ? CAPRST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Offset removal in signed arithmetic so small captures clamp to zero instead of wrapping.
  always_comb begin
    ovf_sum = ovf_acc | timeout;
    for (int k = 0; k < NCH; k++) begin
      diff[k] = $signed({1'b0, cap_val[k]}) - OFF_S;
      if (diff[k] < 0)          result[k] = '0;
      else if (diff[k] > SAT_S) result[k] = '1;
      else                      result[k] = diff[k][OUT_W-1:0];
      acc_sum[k] = acc[k] + ACC_W'(result[k]);
      avg_val[k] = acc_sum[k] >> AVG_LOG2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rc_cnt     <= '0;
      win_cnt    <= '0;
      captured   <= '0;
      timeout    <= '0;
      ovf_acc    <= '0;
      data_out   <= '0;
      ovf        <= '0;
      data_valid <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        cap_val[k] <= '0;
        acc[k]     <= '0;
      end
    end else begin
      data_valid <= 1'b0;
      case (state)
        CAPRST: begin
          cnt      <= '0;
          captured <= '0;
          timeout  <= '0;
          rc_cnt   <= rc_cnt + 1'b1;
        end
        RAMP: begin
          cnt <= cnt + 1'b1;
          for (int k = 0; k < NCH; k++) begin
            if (!captured[k]) begin
              if (rise[k]) begin
                cap_val[k]  <= cnt;
                captured[k] <= 1'b1;
              end else if (cnt == CNT_MAX) begin
                cap_val[k] <= CNT_MAX;
                timeout[k] <= 1'b1;
              end
            end
          end
        end
        // The last conversion of a window publishes the average and restarts the window.
        DONE: begin
          rc_cnt <= '0;
          if (win_cnt == WIN_LAST) begin
            for (int k = 0; k < NCH; k++) begin
              data_out[k*OUT_W +: OUT_W] <= avg_val[k][OUT_W-1:0];
              acc[k] <= '0;
            end
            ovf        <= ovf_sum;
            data_valid <= 1'b1;
            ovf_acc    <= '0;
            win_cnt    <= '0;
          end else begin
            for (int k = 0; k < NCH; k++) acc[k] <= acc_sum[k];
            ovf_acc <= ovf_sum;
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: rc_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ttd_multi.sv
// Directed bench for ttd_multi: one instance without averaging, one averaging
// four conversions in continuous mode.
module tb_ttd_multi;

  logic        clk;
  logic        rst_a, start_a, continuous_a, rst_cap_a, busy_a, data_valid_a;
  logic [1:0]  cmp_a, ovf_a;
  logic [15:0] data_out_a;
  logic        rst_b, start_b, continuous_b, rst_cap_b, busy_b, data_valid_b;
  logic [1:0]  cmp_b, ovf_b;
  logic [15:0] data_out_b;

  int errors = 0;
  int checks = 0;
  int conv0 [8];
  int conv1 [8];

  ttd_multi #(.CNT_W(11), .OUT_W(8), .NCH(2), .OFFSET(509), .RST_CYC(4), .AVG_LOG2(0)) dut_a (
    .clk(clk), .rst(rst_a), .cmp_in(cmp_a), .start(start_a), .continuous(continuous_a),
    .rst_cap(rst_cap_a), .busy(busy_a), .data_out(data_out_a), .ovf(ovf_a),
    .data_valid(data_valid_a)
  );

  ttd_multi #(.CNT_W(11), .OUT_W(8), .NCH(2), .OFFSET(509), .RST_CYC(4), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst(rst_b), .cmp_in(cmp_b), .start(start_b), .continuous(continuous_b),
    .rst_cap(rst_cap_b), .busy(busy_b), .data_out(data_out_b), .ovf(ovf_b),
    .data_valid(data_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Single conversion on dut_a; a capture value below zero means the channel never rises.
  task automatic applyStimulus(input int x0, input int x1, input logic [7:0] e0,
                               input logic [7:0] e1, input logic [1:0] eovf, input bit chk_cap);
    int last;
    int exp_idx;
    int nvalid;
    bit fin;
    last    = (x0 < 0 || x1 < 0) ? 2047 : ((x0 > x1) ? x0 : x1);
    exp_idx = last + 6;
    nvalid  = 0;
    fin     = 1'b0;
    start_a = 1'b1;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start_a = 1'b0;
        checkOutput("a_busy_start", busy_a, 1);
      end
      if (chk_cap && i < 4) checkOutput("a_rst_cap_caprst", rst_cap_a, 1);
      if (chk_cap && i == 4) checkOutput("a_rst_cap_ramp", rst_cap_a, 0);
      if (data_valid_a) begin
        nvalid++;
        if (nvalid == 1) begin
          checkOutput("a_valid_idx", i, exp_idx);
          checkOutput("a_ch0", data_out_a[7:0], e0);
          checkOutput("a_ch1", data_out_a[15:8], e1);
          checkOutput("a_ovf", ovf_a, eovf);
        end
      end
      if (x0 >= 0 && i == x0 + 2) cmp_a[0] = 1'b1;
      if (x1 >= 0 && i == x1 + 2) cmp_a[1] = 1'b1;
      if (i == exp_idx + 1) begin
        checkOutput("a_valid_pulse_len", data_valid_a, 0);
        checkOutput("a_busy_idle", busy_a, 0);
        checkOutput("a_ch0_hold", data_out_a[7:0], e0);
        checkOutput("a_valid_count", nvalid, 1);
        fin = 1'b1;
      end
    end
    if (!fin) checkOutput("a_timeout", 0, 1);
    cmp_a = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  // Continuous run on dut_b over conv0/conv1; optional reset at count 300 of conversion rst_conv.
  task automatic runContinuous(input int n, input int rst_conv, input int exp_idx,
                               input logic [7:0] e0, input logic [7:0] e1);
    int m;
    int s;
    int last;
    int nvalid;
    bit fin;
    m = 0;
    s = 0;
    nvalid = 0;
    fin = 1'b0;
    continuous_b = 1'b1;
    for (int i = 0; i < 12000 && !fin; i++) begin
      @(negedge clk);
      last = (conv0[m] > conv1[m]) ? conv0[m] : conv1[m];
      if (data_valid_b) begin
        nvalid++;
        checkOutput("b_valid_idx", i, exp_idx);
        checkOutput("b_ch0_avg", data_out_b[7:0], e0);
        checkOutput("b_ch1_avg", data_out_b[15:8], e1);
        checkOutput("b_ovf", ovf_b, 0);
      end
      if (rst_conv < 0 && m == n - 1 && i == s + 5) continuous_b = 1'b0;
      if (m == rst_conv && i == s + 305) begin
        checkOutput("b_rst_busy", busy_b, 0);
        checkOutput("b_rst_cap", rst_cap_b, 1);
        checkOutput("b_rst_data", data_out_b, 0);
        rst_b = 1'b0;
        continuous_b = 1'b0;
        fin = 1'b1;
      end else if (m == rst_conv && i == s + 304) begin
        rst_b = 1'b1;
      end
      if (i == s + conv0[m] + 2) cmp_b[0] = 1'b1;
      if (i == s + conv1[m] + 2) cmp_b[1] = 1'b1;
      if (!fin && i == s + last + 6) begin
        m++;
        s = i;
        cmp_b = 2'b00;
        if (m == n) begin
          checkOutput("b_busy_end", busy_b, 0);
          fin = 1'b1;
        end
      end
    end
    if (!fin) checkOutput("b_timeout", 0, 1);
    checkOutput("b_valid_count", nvalid, (rst_conv < 0) ? 1 : 0);
    cmp_b = 2'b00;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; continuous_a = 1'b0; cmp_a = 2'b00;
    rst_b = 1'b1; start_b = 1'b0; continuous_b = 1'b0; cmp_b = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    checkOutput("rst_data_out", data_out_a, 0);
    checkOutput("rst_ovf", ovf_a, 0);
    checkOutput("rst_valid", data_valid_a, 0);
    checkOutput("rst_rst_cap", rst_cap_a, 1);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_b_data_out", data_out_b, 0);
    repeat (5) @(negedge clk);
    checkOutput("idle_busy", busy_a, 0);
    checkOutput("idle_rst_cap", rst_cap_a, 1);

    $display("[TB] nominal conversion");
    applyStimulus(600, 700, 8'd91, 8'd191, 2'b00, 1'b1);
    $display("[TB] saturation");
    applyStimulus(400, 900, 8'd0, 8'd255, 2'b00, 1'b0);
    $display("[TB] timeout on ch1");
    applyStimulus(600, -1, 8'd91, 8'd255, 2'b10, 1'b0);

    $display("[TB] averaging window");
    conv0[0] = 600; conv0[1] = 602; conv0[2] = 604; conv0[3] = 606;
    conv1[0] = 700; conv1[1] = 701; conv1[2] = 702; conv1[3] = 703;
    conv0[4] = 600; conv1[4] = 600;
    runContinuous(4, -1, 2830, 8'd94, 8'd192);

    $display("[TB] reset mid-ramp");
    conv0[0] = 900; conv0[1] = 900; conv0[2] = 1000;
    conv1[0] = 900; conv1[1] = 900; conv1[2] = 1000;
    runContinuous(3, 2, -1, 8'd0, 8'd0);

    $display("[TB] fresh window after reset");
    conv0[0] = 520; conv0[1] = 530; conv0[2] = 540; conv0[3] = 550;
    conv1[0] = 710; conv1[1] = 710; conv1[2] = 710; conv1[3] = 710;
    conv0[4] = 600; conv1[4] = 600;
    runContinuous(4, -1, 2864, 8'd26, 8'd201);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
